// File: rtl/keypad_time_entry.sv
// keypad_time_entry
// Collects keypad digits into a six-digit BCD time HH:MM:SS. Each digit is
// range-checked as it is typed. Backspace, clear, cancel and an inactivity
// timeout edit or discard the entry. Enter commits a complete entry, and the
// committed time is offered to the RTC writer over a valid/ready handshake.
module keypad_time_entry #(
    parameter int P_CNT_1MS    = 100_000,  // clock cycles per 1 ms tick
    parameter int P_TIMEOUT_MS = 10_000    // idle ms before a partial entry is dropped
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [3:0]  i_key,
    input  logic        i_key_valid,
    output logic [23:0] o_entry,
    output logic [2:0]  o_digit_cnt,
    output logic        o_editing,
    output logic        o_err,
    output logic [23:0] o_set_time,
    output logic        o_set_valid,
    input  logic        i_set_ready
);

    localparam int PRE_W = (P_CNT_1MS > 1) ? $clog2(P_CNT_1MS) : 1;
    localparam int TO_W  = (P_TIMEOUT_MS > 1) ? $clog2(P_TIMEOUT_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(P_CNT_1MS - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(P_TIMEOUT_MS - 1);

    localparam logic [3:0] K_ENTER  = 4'hA;
    localparam logic [3:0] K_BACK   = 4'hB;
    localparam logic [3:0] K_CLEAR  = 4'hC;
    localparam logic [3:0] K_CANCEL = 4'hD;

    typedef enum logic {
        S_EDIT,
        S_PEND
    } state_t;

    state_t           state;
    logic [PRE_W-1:0] presc;
    logic [TO_W-1:0]  to_cnt;
    logic             tick;

    // Range limit for a digit typed at position pos. Position 0 is the hours
    // tens digit. The hours units digit is limited to 0-3 when the hours tens
    // digit is 2, so that the largest hour is 23.
    function automatic logic digit_allowed(input logic [2:0] pos, input logic [3:0] d,
                                           input logic [3:0] hours_tens);
        case (pos)
            3'd0:       return d <= 4'd2;
            3'd1:       return (hours_tens == 4'd2) ? (d <= 4'd3) : (d <= 4'd9);
            3'd2, 3'd4: return d <= 4'd5;
            3'd3, 3'd5: return d <= 4'd9;
            default:    return 1'b0;
        endcase
    endfunction

    // Return the entry with the BCD digit at position pos replaced by d.
    function automatic logic [23:0] put_digit(input logic [23:0] e, input logic [2:0] pos,
                                              input logic [3:0] d);
        logic [23:0] r;
        r = e;
        case (pos)
            3'd0:    r[23:20] = d;
            3'd1:    r[19:16] = d;
            3'd2:    r[15:12] = d;
            3'd3:    r[11:8]  = d;
            3'd4:    r[7:4]   = d;
            3'd5:    r[3:0]   = d;
            default: r = e;
        endcase
        return r;
    endfunction

    // The 1 ms tick fires on the last count of the free-running prescaler.
    assign tick = (presc == PRE_LAST);

    // The display shows editing only while at least one digit has been typed.
    assign o_editing = (state == S_EDIT) && (o_digit_cnt != 3'd0);

    // Main control: key handling, commit handshake, prescaler and inactivity timeout.
    always_ff @(posedge i_clk) begin
        // NOTE: every register here is written with <=, so all reads in this
        // block see the values from before the clock edge.
        if (i_reset) begin
            state       <= S_EDIT;
            presc       <= '0;
            to_cnt      <= '0;
            o_entry     <= '0;
            o_digit_cnt <= '0;
            o_err       <= 1'b0;
            o_set_time  <= '0;
            o_set_valid <= 1'b0;
        end else begin
            o_err <= 1'b0;
            presc <= tick ? '0 : presc + 1'b1;

            case (state)
                S_EDIT: begin
                    if (i_key_valid) begin
                        // Any key, accepted or rejected, restarts the idle
                        // count. It also wins over an expiry in the same cycle.
                        to_cnt <= '0;
                        if (i_key <= 4'd9) begin
                            if (o_digit_cnt < 3'd6 &&
                                digit_allowed(o_digit_cnt, i_key, o_entry[23:20])) begin
                                o_entry     <= put_digit(o_entry, o_digit_cnt, i_key);
                                o_digit_cnt <= o_digit_cnt + 3'd1;
                            end else begin
                                o_err <= 1'b1;
                            end
                        end else begin
                            case (i_key)
                                K_ENTER: begin
                                    if (o_digit_cnt == 3'd6) begin
                                        o_set_time  <= o_entry;
                                        o_set_valid <= 1'b1;
                                        state       <= S_PEND;
                                        o_entry     <= '0;
                                        o_digit_cnt <= '0;
                                    end else begin
                                        o_err <= 1'b1;
                                    end
                                end
                                K_BACK: begin
                                    if (o_digit_cnt != 3'd0) begin
                                        o_entry     <= put_digit(o_entry, o_digit_cnt - 3'd1, 4'd0);
                                        o_digit_cnt <= o_digit_cnt - 3'd1;
                                    end
                                end
                                K_CLEAR, K_CANCEL: begin
                                    o_entry     <= '0;
                                    o_digit_cnt <= '0;
                                end
                                default: ;  // 0xE and 0xF are ignored silently
                            endcase
                        end
                    end else if (o_digit_cnt == 3'd0) begin
                        to_cnt <= '0;
                    end else if (tick) begin
                        if (to_cnt == TO_LAST) begin
                            o_entry     <= '0;
                            o_digit_cnt <= '0;
                            to_cnt      <= '0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end

                S_PEND: begin
                    // Keys are discarded while the committed time is being
                    // offered, including a key in the cycle the handshake completes.
                    to_cnt <= '0;
                    if (i_set_ready) begin
                        o_set_valid <= 1'b0;
                        state       <= S_EDIT;
                    end
                end

                default: state <= S_EDIT;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_time_entry.sv
// tb_keypad_time_entry
// Directed bench for keypad_time_entry. The timeout is shortened to 3 ticks
// of 10 cycles. Inputs are driven on the falling edge and outputs are
// sampled on the falling edge, one cycle after the key is sampled.
module tb_keypad_time_entry;

    localparam int CNT_1MS    = 10;
    localparam int TIMEOUT_MS = 3;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [3:0]  i_key;
    logic        i_key_valid;
    logic [23:0] o_entry;
    logic [2:0]  o_digit_cnt;
    logic        o_editing;
    logic        o_err;
    logic [23:0] o_set_time;
    logic        o_set_valid;
    logic        i_set_ready;

    int checks = 0;
    int errors = 0;
    int phase  = 0;  // expected prescaler value in the current cycle

    keypad_time_entry #(
        .P_CNT_1MS   (CNT_1MS),
        .P_TIMEOUT_MS(TIMEOUT_MS)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_key      (i_key),
        .i_key_valid(i_key_valid),
        .o_entry    (o_entry),
        .o_digit_cnt(o_digit_cnt),
        .o_editing  (o_editing),
        .o_err      (o_err),
        .o_set_time (o_set_time),
        .o_set_valid(o_set_valid),
        .i_set_ready(i_set_ready)
    );

    always #5 i_clk = ~i_clk;

    // Free-running 1 ms prescaler phase, used to place a key in the expiry cycle.
    always @(posedge i_clk) begin
        if (i_reset) phase <= 0;
        else         phase <= (phase == CNT_1MS - 1) ? 0 : phase + 1;
    end

    // Watchdog so the run can never hang.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required finish");
        $fatal(1, "watchdog");
    end

    // Drive one key for one cycle and return in the following cycle (outputs visible).
    task automatic press(input logic [3:0] k);
        i_key       = k;
        i_key_valid = 1'b1;
        @(negedge i_clk);
        i_key_valid = 1'b0;
    endtask

    task automatic expect_state(input string name, input logic [23:0] entry,
                                input logic [2:0] cnt, input logic err);
        checks++;
        if (o_entry !== entry || o_digit_cnt !== cnt || o_err !== err) begin
            errors++;
            $display("FAIL %s: got entry=%h cnt=%0d err=%b, expected entry=%h cnt=%0d err=%b",
                     name, o_entry, o_digit_cnt, o_err, entry, cnt, err);
        end
    endtask

    task automatic test_reset;
        i_reset = 1'b1; i_key = 4'h0; i_key_valid = 1'b0; i_set_ready = 1'b0;
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_entry !== 24'h0 || o_digit_cnt !== 3'd0 || o_editing !== 1'b0 || o_err !== 1'b0 ||
            o_set_time !== 24'h0 || o_set_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset: got entry=%h cnt=%0d edit=%b err=%b time=%h valid=%b, expected all 0",
                     o_entry, o_digit_cnt, o_editing, o_err, o_set_time, o_set_valid);
        end
    endtask

    task automatic test_enter_commit;
        logic [23:0] exp_e [6] = '{24'h100000, 24'h120000, 24'h123000,
                                   24'h123400, 24'h123450, 24'h123456};
        for (int i = 0; i < 6; i++) begin
            press(4'(i + 1));
            expect_state("commit_digit", exp_e[i], 3'(i + 1), 1'b0);
        end
        checks++;
        if (o_editing !== 1'b1) begin
            errors++;
            $display("FAIL editing_high: got %b, expected 1", o_editing);
        end
        press(4'hA);
        expect_state("commit_enter_clears", 24'h0, 3'd0, 1'b0);
        repeat (3) @(negedge i_clk);
        checks++;
        if (o_set_valid !== 1'b1 || o_set_time !== 24'h123456) begin
            errors++;
            $display("FAIL commit_offer: got valid=%b time=%h, expected valid=1 time=123456",
                     o_set_valid, o_set_time);
        end
        i_set_ready = 1'b1;
        @(negedge i_clk);
        i_set_ready = 1'b0;
        checks++;
        if (o_set_valid !== 1'b0 || o_entry !== 24'h0) begin
            errors++;
            $display("FAIL commit_handshake: got valid=%b entry=%h, expected valid=0 entry=000000",
                     o_set_valid, o_entry);
        end
    endtask

    task automatic test_range_check;
        press(4'd2); expect_state("range_p0_2", 24'h200000, 3'd1, 1'b0);
        press(4'd4); expect_state("range_p1_4_after_2", 24'h200000, 3'd1, 1'b1);
        press(4'd3); expect_state("range_p1_3_after_2", 24'h230000, 3'd2, 1'b0);
        press(4'd6); expect_state("range_p2_6", 24'h230000, 3'd2, 1'b1);
        press(4'd5); expect_state("range_p2_5", 24'h235000, 3'd3, 1'b0);
        press(4'hC); expect_state("range_clear", 24'h0, 3'd0, 1'b0);
        press(4'd3); expect_state("range_p0_3", 24'h0, 3'd0, 1'b1);
        press(4'd1); press(4'd9); expect_state("range_p1_9_after_1", 24'h190000, 3'd2, 1'b0);
        press(4'hD); expect_state("range_cancel", 24'h0, 3'd0, 1'b0);
    endtask

    task automatic test_overflow_and_errors;
        logic [3:0] digs [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9};
        for (int i = 0; i < 6; i++) press(digs[i]);
        expect_state("full_entry", 24'h123459, 3'd6, 1'b0);
        press(4'd7); expect_state("seventh_digit", 24'h123459, 3'd6, 1'b1);
        press(4'hC);
        press(4'd1); press(4'd2); press(4'd3);
        press(4'hA); expect_state("enter_short", 24'h123000, 3'd3, 1'b1);
        checks++;
        if (o_set_valid !== 1'b0) begin
            errors++;
            $display("FAIL enter_short_valid: got %b, expected 0", o_set_valid);
        end
        press(4'hC);
        press(4'hB); expect_state("back_at_zero", 24'h0, 3'd0, 1'b0);
    endtask

    task automatic test_backspace_clear;
        press(4'd1); press(4'd2);
        press(4'hE); expect_state("ignored_E", 24'h120000, 3'd2, 1'b0);
        press(4'hB); expect_state("backspace", 24'h100000, 3'd1, 1'b0);
        press(4'hF); expect_state("ignored_F", 24'h100000, 3'd1, 1'b0);
        press(4'hC); expect_state("clear", 24'h0, 3'd0, 1'b0);
        checks++;
        if (o_editing !== 1'b0) begin
            errors++;
            $display("FAIL clear_editing: got %b, expected 0", o_editing);
        end
    endtask

    task automatic test_back_to_back;
        // Two rejected keys in consecutive cycles give two consecutive pulses.
        i_key = 4'd9; i_key_valid = 1'b1;
        @(negedge i_clk);
        expect_state("b2b_err_first", 24'h0, 3'd0, 1'b1);
        @(negedge i_clk);
        i_key_valid = 1'b0;
        expect_state("b2b_err_second", 24'h0, 3'd0, 1'b1);
        @(negedge i_clk);
        expect_state("b2b_err_drop", 24'h0, 3'd0, 1'b0);
        // Two accepted digits in consecutive cycles.
        i_key = 4'd2; i_key_valid = 1'b1;
        @(negedge i_clk);
        i_key = 4'd1;
        @(negedge i_clk);
        i_key_valid = 1'b0;
        expect_state("b2b_digits", 24'h210000, 3'd2, 1'b0);
        press(4'hC);
    endtask

    task automatic test_timeout;
        int err_seen;
        int ticks;
        err_seen = 0;
        press(4'd1);
        for (int i = 0; i < 14; i++) begin
            if (o_err) err_seen++;
            @(negedge i_clk);
        end
        expect_state("timeout_not_yet", 24'h100000, 3'd1, 1'b0);
        for (int i = 0; i < 17; i++) begin
            if (o_err) err_seen++;
            @(negedge i_clk);
        end
        expect_state("timeout_expired", 24'h0, 3'd0, 1'b0);
        checks++;
        if (err_seen != 0) begin
            errors++;
            $display("FAIL timeout_no_err: got %0d err pulses, expected 0", err_seen);
        end
        // Key 5 lands in the cycle of the third tick after key 1, the expiry cycle.
        press(4'd1);
        ticks = 0;
        for (int i = 0; i < 40 && ticks < TIMEOUT_MS; i++) begin
            if (phase == CNT_1MS - 1) ticks++;
            if (ticks == TIMEOUT_MS) press(4'd5);
            else @(negedge i_clk);
        end
        expect_state("timeout_key_wins", 24'h150000, 3'd2, 1'b0);
        press(4'hC);
    endtask

    task automatic test_pend_keys;
        logic [3:0] digs [6] = '{4'd0, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9};
        for (int i = 0; i < 6; i++) press(digs[i]);
        press(4'hA);
        press(4'd5); expect_state("pend_key_ignored", 24'h0, 3'd0, 1'b0);
        checks++;
        if (o_set_valid !== 1'b1 || o_set_time !== 24'h095959) begin
            errors++;
            $display("FAIL pend_hold: got valid=%b time=%h, expected valid=1 time=095959",
                     o_set_valid, o_set_time);
        end
        i_key = 4'd9; i_key_valid = 1'b1; i_set_ready = 1'b1;
        @(negedge i_clk);
        i_key_valid = 1'b0; i_set_ready = 1'b0;
        expect_state("pend_key_and_ready", 24'h0, 3'd0, 1'b0);
        checks++;
        if (o_set_valid !== 1'b0) begin
            errors++;
            $display("FAIL pend_ready_valid: got %b, expected 0", o_set_valid);
        end
        press(4'd2); expect_state("edit_after_pend", 24'h200000, 3'd1, 1'b0);
        press(4'hC);
    endtask

    task automatic test_reset_in_pend;
        logic [3:0] digs [6] = '{4'd2, 4'd3, 4'd5, 4'd9, 4'd0, 4'd1};
        for (int i = 0; i < 6; i++) press(digs[i]);
        press(4'hA);
        press(4'd1);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        checks++;
        if (o_entry !== 24'h0 || o_digit_cnt !== 3'd0 || o_editing !== 1'b0 || o_err !== 1'b0 ||
            o_set_time !== 24'h0 || o_set_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_pend: got entry=%h cnt=%0d edit=%b err=%b time=%h valid=%b, expected all 0",
                     o_entry, o_digit_cnt, o_editing, o_err, o_set_time, o_set_valid);
        end
        press(4'd1); expect_state("edit_after_reset", 24'h100000, 3'd1, 1'b0);
    endtask

    initial begin
        test_reset;
        test_enter_commit;
        test_range_check;
        test_overflow_and_errors;
        test_backspace_clear;
        test_back_to_back;
        test_timeout;
        test_pend_keys;
        test_reset_in_pend;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
